cache_fill_controller: RTL and testbench



---
 rtl/cache_fill_controller.sv | 151 +++++++++++++++
 tb/tb_cache_fill_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_controller.sv
// Lookup, LRU update and miss-fill sequencer for a 2-way, 64-set cache with 8-word blocks.
// The tag compare, stall and hit-path LRU pulses are combinational; fill progress is tracked by a small FSM.
module cache_fill_controller #(
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    input  logic [7:0]  way0_meta,
    input  logic [7:0]  way1_meta,
    input  logic        mem_data_valid,
    output logic [63:0] set_enable,
    output logic [1:0]  meta_wen,
    output logic [1:0]  meta_lru_en,
    output logic [7:0]  meta_data0,
    output logic [7:0]  meta_data1,
    output logic        data_wen,
    output logic        data_way,
    output logic [7:0]  data_word_en,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    output logic        hit,
    output logic        hit_way,
    output logic        stall
);

    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);
    localparam logic [3:0] NUM_WORDS = 4'(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT,
        META
    } state_t;

    state_t     state;
    logic [3:0] issue_cnt;
    logic [3:0] recv_cnt;
    logic       victim;

    logic [5:0] tag;
    logic [5:0] index;
    logic       match0;
    logic       match1;
    logic       miss;
    logic       recv_fire;
    logic       victim_sel;
    logic       unused_addr_bits;

    assign tag              = req_addr[15:10];
    assign index            = req_addr[9:4];
    assign unused_addr_bits = ^req_addr[3:0];

    always_comb begin
        match0 = way0_meta[6] && (way0_meta[5:0] == tag);
        match1 = way1_meta[6] && (way1_meta[5:0] == tag);
        hit     = req_valid && (state == IDLE) && (match0 || match1);
        hit_way = hit && !match0;
        miss    = req_valid && (state == IDLE) && !(match0 || match1);
        stall   = (state != IDLE) || miss;
        set_enable = 64'd1 << index;
    end

    // Invalid ways are filled first (way 0 preferred); otherwise the way flagged LRU, ties to way 0.
    always_comb begin
        if (!way0_meta[6]) begin
            victim_sel = 1'b0;
        end else if (!way1_meta[6]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = way1_meta[7] && !way0_meta[7];
        end
    end

    always_comb begin
        recv_fire    = mem_data_valid && ((state == FILL) || (state == WAIT)) && (recv_cnt < NUM_WORDS);
        data_wen     = recv_fire;
        data_way     = recv_fire ? victim : 1'b0;
        data_word_en = recv_fire ? (8'd1 << recv_cnt[2:0]) : '0;
        mem_rd_en    = (state == FILL);
        mem_addr     = (state == FILL) ? {req_addr[15:4], issue_cnt[2:0], 1'b0} : '0;
    end

    always_comb begin
        meta_wen    = '0;
        meta_lru_en = '0;
        meta_data0  = '0;
        meta_data1  = '0;
        if (hit) begin
            meta_lru_en = 2'b11;
            meta_data0  = {hit_way, way0_meta[6:0]};
            meta_data1  = {!hit_way, way1_meta[6:0]};
        end else if (state == META) begin
            if (victim) begin
                meta_wen[1]    = 1'b1;
                meta_lru_en[0] = 1'b1;
                meta_data1     = {2'b01, tag};
                meta_data0     = {1'b1, way0_meta[6:0]};
            end else begin
                meta_wen[0]    = 1'b1;
                meta_lru_en[1] = 1'b1;
                meta_data0     = {2'b01, tag};
                meta_data1     = {1'b1, way1_meta[6:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            victim    <= 1'b0;
        end else begin
            if (recv_fire) begin
                recv_cnt <= recv_cnt + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (miss) begin
                        victim    <= victim_sel;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    issue_cnt <= issue_cnt + 4'd1;
                    if (issue_cnt == LAST_WORD) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Look ahead at the arriving word so META follows the last write by one cycle.
                    if ((recv_cnt == NUM_WORDS) || (recv_fire && (recv_cnt == LAST_WORD))) begin
                        state <= META;
                    end
                end
                META: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed and random accesses against a set/way/LRU reference model, with behavioural metadata
// arrays and a fixed-latency pipelined memory around the controller.
module tb_cache_fill_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = '0;
    logic        mem_data_valid = 1'b0;
    logic [7:0]  way0_meta;
    logic [7:0]  way1_meta;
    logic [63:0] set_enable;
    logic [1:0]  meta_wen;
    logic [1:0]  meta_lru_en;
    logic [7:0]  meta_data0;
    logic [7:0]  meta_data1;
    logic        data_wen;
    logic        data_way;
    logic [7:0]  data_word_en;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        hit;
    logic        hit_way;
    logic        stall;

    cache_fill_controller #(.WORDS_PER_BLOCK(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .way0_meta(way0_meta), .way1_meta(way1_meta), .mem_data_valid(mem_data_valid),
        .set_enable(set_enable), .meta_wen(meta_wen), .meta_lru_en(meta_lru_en),
        .meta_data0(meta_data0), .meta_data1(meta_data1), .data_wen(data_wen),
        .data_way(data_way), .data_word_en(data_word_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .hit(hit), .hit_way(hit_way), .stall(stall)
    );

    always #5 clk = ~clk;

    // Metadata arrays as the surrounding cache would hold them.
    logic [7:0] arr0 [64];
    logic [7:0] arr1 [64];
    assign way0_meta = arr0[req_addr[9:4]];
    assign way1_meta = arr1[req_addr[9:4]];

    always @(posedge clk) begin
        if (meta_wen[0]) arr0[req_addr[9:4]] <= meta_data0;
        else if (meta_lru_en[0]) arr0[req_addr[9:4]][7] <= meta_data0[7];
        if (meta_wen[1]) arr1[req_addr[9:4]] <= meta_data1;
        else if (meta_lru_en[1]) arr1[req_addr[9:4]][7] <= meta_data1[7];
    end

    // Reference cache state: valid, tag and "this way is LRU" per way and set.
    bit         rv [2][64];
    logic [5:0] rt [2][64];
    bit         rl [2][64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int q[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() != 0 && q[0] == cyc) begin
            mem_data_valid = 1'b1;
            void'(q.pop_front());
        end else begin
            mem_data_valid = 1'b0;
        end
    endtask

    task automatic hit_pulse(input int s, input int w);
        chk("hit_meta_wen", meta_wen, 2'b00);
        chk("hit_lru_en", meta_lru_en, 2'b11);
        chk("hit_lru_bit0", meta_data0[7], (w == 1));
        chk("hit_lru_bit1", meta_data1[7], (w == 0));
        rl[w][s] = 1'b0;
        rl[1-w][s] = 1'b1;
    endtask

    task automatic access(input logic [15:0] a, input int lat, input int abort_after);
        int s, ew, v, issues, writes, last_wr;
        logic [5:0] t;
        bit eh, done;
        s = int'(a[9:4]);
        t = a[15:10];
        eh = 1'b0;
        ew = 0;
        if (rv[0][s] && rt[0][s] == t) begin
            eh = 1'b1; ew = 0;
        end else if (rv[1][s] && rt[1][s] == t) begin
            eh = 1'b1; ew = 1;
        end
        advance();
        req_valid = 1'b1;
        req_addr = a;
        @(negedge clk);
        chk("set_enable", set_enable, 64'd1 << s);
        chk("hit", hit, eh);
        chk("hit_way", hit_way, ew);
        chk("stall", stall, !eh);
        if (eh) begin
            hit_pulse(s, ew);
        end else begin
            if (!rv[0][s]) v = 0;
            else if (!rv[1][s]) v = 1;
            else if (rl[1][s] && !rl[0][s]) v = 1;
            else v = 0;
            chk("miss_no_issue", mem_rd_en, 1'b0);
            issues = 0; writes = 0; last_wr = 0; done = 1'b0;
            for (int n = 0; n < 300 && !done; n++) begin
                advance();
                if (abort_after > 0 && writes == abort_after) begin
                    rst = 1'b0;
                    req_valid = 1'b0;
                    mem_data_valid = 1'b0;
                    q.delete();
                    for (int k = 0; k < 2; k++) begin
                        advance();
                        @(negedge clk);
                        chk("abort_stall", stall, 1'b0);
                        chk("abort_rd_en", mem_rd_en, 1'b0);
                        chk("abort_meta_wen", meta_wen, 2'b00);
                        chk("abort_data_wen", data_wen, 1'b0);
                    end
                    rst = 1'b1;
                    return;
                end
                @(negedge clk);
                chk("fill_stall", stall, 1'b1);
                chk("fill_hit", hit, 1'b0);
                if (mem_rd_en) begin
                    chk("mem_addr", mem_addr, {a[15:4], 3'(issues), 1'b0});
                    issues++;
                    q.push_back(cyc + lat);
                end
                if (data_wen) begin
                    chk("data_way", data_way, v);
                    chk("data_word_en", data_word_en, 8'd1 << writes);
                    writes++;
                    if (writes == 8) last_wr = cyc;
                end
                if (meta_wen != 2'b00) begin
                    done = 1'b1;
                    chk("meta_wen", meta_wen, (v == 1) ? 2'b10 : 2'b01);
                    chk("meta_lru_en", meta_lru_en, (v == 1) ? 2'b01 : 2'b10);
                    chk("meta_victim_data", (v == 1) ? meta_data1 : meta_data0, {2'b01, t});
                    chk("meta_other_lru", (v == 1) ? meta_data0[7] : meta_data1[7], 1'b1);
                    chk("meta_after_last", cyc - last_wr, 1);
                end else begin
                    chk("fill_lru_en", meta_lru_en, 2'b00);
                end
            end
            if (!done) chk("fill_timeout", 0, 1);
            chk("issue_count", issues, 8);
            chk("write_count", writes, 8);
            rv[v][s] = 1'b1;
            rt[v][s] = t;
            rl[v][s] = 1'b0;
            rl[1-v][s] = 1'b1;
            advance();
            @(negedge clk);
            chk("replay_hit", hit, 1'b1);
            chk("replay_way", hit_way, v);
            chk("replay_stall", stall, 1'b0);
            hit_pulse(s, v);
        end
        advance();
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            arr0[i] = '0;
            arr1[i] = '0;
        end
        rst = 1'b0;
        advance();
        advance();
        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_data_wen", data_wen, 1'b0);
        chk("rst_word_en", data_word_en, 8'h00);
        chk("rst_meta_wen", meta_wen, 2'b00);
        chk("rst_lru_en", meta_lru_en, 2'b00);
        chk("rst_meta_data0", meta_data0, 8'h00);
        chk("rst_meta_data1", meta_data1, 8'h00);
        rst = 1'b1;

        access(16'h1234, 4, 0);   // cold miss into way 0, installs 8'h44
        access(16'h1634, 3, 0);   // tag 5 same set -> way 1 gets 8'h45
        access(16'h1234, 1, 0);   // hit way 0
        access(16'h1636, 1, 0);   // hit way 1, way 0 becomes LRU
        access(16'h1A30, 2, 0);   // both valid, way 0 LRU -> victim 0
        access(16'h0A50, 1, 0);   // latency 1: data overlaps FILL
        access(16'h0E70, 6, 3);   // reset during WAIT after 3 words
        access(16'h0E70, 5, 0);   // same request refills all 8 words

        for (int i = 0; i < 30; i++) begin
            logic [5:0] rs;
            logic [15:0] ra;
            case ($urandom_range(0, 2))
                0: rs = 6'h23;
                1: rs = 6'h05;
                default: rs = 6'h3F;
            endcase
            ra = {6'($urandom_range(0, 3)), rs, 3'($urandom_range(0, 7)), 1'b0};
            access(ra, int'($urandom_range(1, 5)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
